// File: rtl/sync_fifo_gen2.sv
// Single-clock FIFO with almost thresholds, optional FWFT read mode, sticky errors and flush.
// Latency: standard mode data_out/valid one cycle after rd_en; FWFT head word visible the cycle after it is written.
// Backpressure: writes rejected when full unless a read is accepted in the same cycle; reads rejected when empty.
//
// Ports: clk, rst_n (async active-low), flush (sync clear), wr_en/data_in (write side),
//        rd_en (read / FWFT pop), err_clr (clears sticky errors), data_out/valid (read side),
//        full/almost_full/empty/almost_empty/count (occupancy), overflow/underflow (sticky errors).
module sync_fifo_gen2 #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int PW      = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             full,
    output logic             almost_full,
    output logic             empty,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic rd_acc;
    logic wr_acc;
    logic rd_do;
    logic wr_do;

    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Status flags decode straight from the registered count.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // A read frees a slot in the same cycle, so a write into a full FIFO
    // is accepted alongside it. A read never bypasses an empty FIFO.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    // Flush discards both requests outright.
    assign rd_do = rd_acc & ~flush;
    assign wr_do = wr_acc & ~flush;

    // Storage is not reset; rst_n gates the write so nothing lands while reset is held.
    always_ff @(posedge clk) begin
        if (wr_do && rst_n) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_do) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_do) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_do, rd_do})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky errors: a new error in the same cycle as err_clr keeps the flag set.
    // Requests dropped by flush are not errors.
    logic ovf_set;
    logic udf_set;

    assign ovf_set = wr_en & ~wr_acc & ~flush;
    assign udf_set = rd_en & ~rd_acc & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~err_clr) | ovf_set;
            underflow <= (underflow & ~err_clr) | udf_set;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; zero while empty so the
            // un-reset storage never leaks X onto data_out.
            assign data_out = empty ? '0 : mem[rd_ptr];
            assign valid    = ~empty;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            logic             vld_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else if (flush) begin
                    vld_q  <= 1'b0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                    vld_q  <= 1'b1;
                end else begin
                    vld_q  <= 1'b0;
                end
            end

            assign data_out = dout_q;
            assign valid    = vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_gen2.sv
// Bench for sync_fifo_gen2: three instances (DEPTH 4 standard, DEPTH 5 standard, DEPTH 4 FWFT)
// share the stimulus; each scenario task resets and checks the instance it targets.
// Expected read data comes from a queue filled when writes are driven.
module tb_sync_fifo_gen2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] dout_a, dout_b, dout_c;
    logic       vld_a, vld_b, vld_c;
    logic       full_a, full_b, full_c;
    logic       af_a, af_b, af_c;
    logic       empty_a, empty_b, empty_c;
    logic       ae_a, ae_b, ae_c;
    logic [2:0] cnt_a, cnt_b, cnt_c;
    logic       ovf_a, ovf_b, ovf_c;
    logic       udf_a, udf_b, udf_c;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    sync_fifo_gen2 #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .err_clr(err_clr), .data_out(dout_a), .valid(vld_a),
        .full(full_a), .almost_full(af_a), .empty(empty_a), .almost_empty(ae_a),
        .count(cnt_a), .overflow(ovf_a), .underflow(udf_a));

    sync_fifo_gen2 #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .err_clr(err_clr), .data_out(dout_b), .valid(vld_b),
        .full(full_b), .almost_full(af_b), .empty(empty_b), .almost_empty(ae_b),
        .count(cnt_b), .overflow(ovf_b), .underflow(udf_b));

    sync_fifo_gen2 #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .err_clr(err_clr), .data_out(dout_c), .valid(vld_c),
        .full(full_c), .almost_full(af_c), .empty(empty_c), .almost_empty(ae_c),
        .count(cnt_c), .overflow(ovf_c), .underflow(udf_c));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        flush = 0; wr_en = 0; rd_en = 0; err_clr = 0; data_in = 8'h00;
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        q.delete();
    endtask

    task automatic test_reset;
        rst_n = 0;
        #1;
        checks++; if (cnt_a !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
        checks++; if ({empty_a, ae_a, full_a, af_a} !== 4'b1100) begin errors++; $display("FAIL reset_flags: got %b want 1100", {empty_a, ae_a, full_a, af_a}); end
        checks++; if ({vld_a, ovf_a, udf_a} !== 3'b000) begin errors++; $display("FAIL reset_vld_err: got %b want 000", {vld_a, ovf_a, udf_a}); end
        checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL reset_dout: got %0h want 0", dout_a); end
        checks++; if ({vld_c, dout_c} !== 9'h000) begin errors++; $display("FAIL reset_fwft_out: got %0h want 0", {vld_c, dout_c}); end
    endtask

    task automatic test_fill_overflow;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; data_in = 8'hA1 + 8'(i);
            step();
            q.push_back(8'hA1 + 8'(i));
            checks++; if (cnt_a !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, cnt_a, i + 1); end
            checks++; if (af_a !== (i + 1 >= 2)) begin errors++; $display("FAIL fill_af[%0d]: got %b want %b", i, af_a, (i + 1 >= 2)); end
        end
        data_in = 8'hA5;
        step();
        wr_en = 0;
        checks++; if ({full_a, ovf_a} !== 2'b11) begin errors++; $display("FAIL overflow_flags: got %b want 11", {full_a, ovf_a}); end
        checks++; if (cnt_a !== 3'd4) begin errors++; $display("FAIL overflow_count: got %0d want 4", cnt_a); end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1;
            step();
            rd_en = 0;
            exp_d = q.pop_front();
            checks++; if (vld_a !== 1'b1 || dout_a !== exp_d) begin errors++; $display("FAIL read_data[%0d]: got v=%b %0h want v=1 %0h", i, vld_a, dout_a, exp_d); end
            step();
            checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL read_vld_drop[%0d]: got %b want 0", i, vld_a); end
        end
        checks++; if ({empty_a, udf_a, ovf_a} !== 3'b101) begin errors++; $display("FAIL drained_flags: got %b want 101", {empty_a, udf_a, ovf_a}); end
        err_clr = 1;
        step();
        err_clr = 0;
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ovf_a); end
    endtask

    task automatic test_full_rw;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1; data_in = 8'hA1 + 8'(i);
            step();
            q.push_back(8'hA1 + 8'(i));
        end
        rd_en = 1; data_in = 8'hB5;
        step();
        wr_en = 0;
        exp_d = q.pop_front();
        q.push_back(8'hB5);
        checks++; if (vld_a !== 1'b1 || dout_a !== exp_d) begin errors++; $display("FAIL full_rw_data: got v=%b %0h want v=1 %0h", vld_a, dout_a, exp_d); end
        checks++; if ({cnt_a, ovf_a} !== {3'd4, 1'b0}) begin errors++; $display("FAIL full_rw_state: got cnt=%0d ovf=%b want cnt=4 ovf=0", cnt_a, ovf_a); end
        for (int i = 0; i < 4; i++) begin
            step();
            exp_d = q.pop_front();
            checks++; if (vld_a !== 1'b1 || dout_a !== exp_d) begin errors++; $display("FAIL b2b_read[%0d]: got v=%b %0h want v=1 %0h", i, vld_a, dout_a, exp_d); end
        end
        rd_en = 0;
        step();
        checks++; if ({vld_a, empty_a, udf_a} !== 3'b010) begin errors++; $display("FAIL full_rw_end: got %b want 010", {vld_a, empty_a, udf_a}); end
    endtask

    task automatic test_empty_rw;
        do_reset();
        wr_en = 1; rd_en = 1; data_in = 8'h55;
        step();
        wr_en = 0; rd_en = 0;
        checks++; if ({cnt_a, udf_a, vld_a} !== {3'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL empty_rw: got cnt=%0d udf=%b v=%b want cnt=1 udf=1 v=0", cnt_a, udf_a, vld_a); end
        err_clr = 1;
        step();
        err_clr = 0;
        checks++; if ({udf_a, cnt_a} !== {1'b0, 3'd1}) begin errors++; $display("FAIL udf_clear: got udf=%b cnt=%0d want udf=0 cnt=1", udf_a, cnt_a); end
        rd_en = 1;
        step();
        rd_en = 0;
        checks++; if (vld_a !== 1'b1 || dout_a !== 8'h55) begin errors++; $display("FAIL empty_rw_data: got v=%b %0h want v=1 55", vld_a, dout_a); end
        rd_en = 1; err_clr = 1;
        step();
        rd_en = 0; err_clr = 0;
        checks++; if (udf_a !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", udf_a); end
    endtask

    task automatic test_wrap;
        int mc;
        bit ra, wa;
        do_reset();
        mc = 0;
        for (int i = 0; i < 12; i++) begin
            wr_en = 1; data_in = 8'h10 + 8'(i); rd_en = (i % 3 != 0);
            ra = rd_en && (mc > 0);
            wa = wr_en && ((mc < 5) || ra);
            if (ra) exp_d = q.pop_front();
            step();
            if (wa) q.push_back(8'h10 + 8'(i));
            mc = mc + int'(wa) - int'(ra);
            checks++; if (cnt_b !== 3'(mc)) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, cnt_b, mc); end
            if (ra) begin
                checks++; if (vld_b !== 1'b1 || dout_b !== exp_d) begin errors++; $display("FAIL wrap_data[%0d]: got v=%b %0h want v=1 %0h", i, vld_b, dout_b, exp_d); end
            end
        end
        wr_en = 0;
        for (int k = 0; k < 8 && mc > 0; k++) begin
            rd_en = 1;
            exp_d = q.pop_front();
            step();
            mc--;
            checks++; if (vld_b !== 1'b1 || dout_b !== exp_d) begin errors++; $display("FAIL wrap_drain[%0d]: got v=%b %0h want v=1 %0h", k, vld_b, dout_b, exp_d); end
        end
        rd_en = 0;
        step();
        checks++; if ({empty_b, ovf_b, udf_b} !== 3'b100) begin errors++; $display("FAIL wrap_end: got %b want 100", {empty_b, ovf_b, udf_b}); end
    endtask

    task automatic test_fwft;
        do_reset();
        wr_en = 1; data_in = 8'h3C;
        step();
        wr_en = 0;
        checks++; if (vld_c !== 1'b1 || dout_c !== 8'h3C) begin errors++; $display("FAIL fwft_show: got v=%b %0h want v=1 3c", vld_c, dout_c); end
        step();
        checks++; if (vld_c !== 1'b1 || dout_c !== 8'h3C) begin errors++; $display("FAIL fwft_hold: got v=%b %0h want v=1 3c", vld_c, dout_c); end
        rd_en = 1;
        step();
        rd_en = 0;
        checks++; if ({empty_c, vld_c} !== 2'b10) begin errors++; $display("FAIL fwft_pop: got %b want 10", {empty_c, vld_c}); end
        wr_en = 1; data_in = 8'h11;
        step();
        data_in = 8'h22;
        step();
        wr_en = 0; rd_en = 1;
        checks++; if (dout_c !== 8'h11) begin errors++; $display("FAIL fwft_head1: got %0h want 11", dout_c); end
        step();
        rd_en = 0;
        checks++; if (vld_c !== 1'b1 || dout_c !== 8'h22) begin errors++; $display("FAIL fwft_head2: got v=%b %0h want v=1 22", vld_c, dout_c); end
    endtask

    task automatic test_flush_reset;
        do_reset();
        wr_en = 1;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'h40 + 8'(i);
            step();
        end
        checks++; if (cnt_a !== 3'd3) begin errors++; $display("FAIL pre_flush_count: got %0d want 3", cnt_a); end
        flush = 1; data_in = 8'h4F;
        step();
        flush = 0;
        checks++; if ({cnt_a, empty_a, ovf_a, vld_a} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL flush: got cnt=%0d e=%b ovf=%b v=%b want 0 1 0 0", cnt_a, empty_a, ovf_a, vld_a); end
        data_in = 8'h61;
        step();
        rd_en = 1; data_in = 8'h62;
        step();
        checks++; if (vld_a !== 1'b1 || dout_a !== 8'h61) begin errors++; $display("FAIL post_flush_read: got v=%b %0h want v=1 61", vld_a, dout_a); end
        #2;
        rst_n = 0;
        #1;
        checks++; if ({cnt_a, empty_a, full_a, vld_a, dout_a} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin errors++; $display("FAIL async_reset: got cnt=%0d e=%b f=%b v=%b d=%0h want 0 1 0 0 0", cnt_a, empty_a, full_a, vld_a, dout_a); end
        step();
        rst_n = 1; wr_en = 0; rd_en = 0;
        step();
        checks++; if (cnt_a !== 3'd0) begin errors++; $display("FAIL reset_no_write: got %0d want 0", cnt_a); end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_fwft();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sync_fifo_gen2.md
Name: sync_fifo_gen2

Overview:
Second-generation parameterised single-clock FIFO for the datapath buffering library.
- Adds programmable almost thresholds, a selectable first-word-fall-through (FWFT) read mode, and correct simultaneous read/write at the full and empty boundaries.
- Adds sticky error flags with explicit clear, and a synchronous flush.
- Sits between any producer/consumer pair sharing clk.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 32, storage words (>=2, need not be a power of two)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
Local: CW = $clog2(DEPTH+1) (count width); PW = $clog2(DEPTH) (pointer width, min 1)

Ports:
clk  in  1  single clock; all state changes on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
flush  in  1  synchronous empty-the-FIFO strobe
wr_en  in  1  write request
data_in  in  WIDTH  write data
rd_en  in  1  read request (pop in FWFT mode)
err_clr  in  1  clears sticky overflow/underflow
data_out  out  WIDTH  read data
valid  out  1  data_out holds valid data (see Behaviour)
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_LEVEL
empty  out  1  count == 0
almost_empty  out  1  count <= AE_LEVEL
count  out  CW  words currently stored
overflow  out  1  sticky: write rejected
underflow  out  1  sticky: read rejected

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr = rd_ptr = 0, count = 0, data_out = 0, valid = 0, overflow = underflow = 0. Flags then read empty = 1, almost_empty = 1, full = 0, almost_full = 0.
- Memory contents are not reset.
- Reset asserted mid-operation aborts any transfer in that cycle; no write lands.
- full, empty, almost_full and almost_empty are decoded combinationally from the registered count, so they are exact in the same cycle as count.
- rd_acc = rd_en & !empty.
- wr_acc = wr_en & (!full | rd_acc): writing while full is accepted if a read is accepted in the same cycle.
- A read while empty is never accepted, even with a simultaneous write.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Pointers: write at mem[wr_ptr]; each pointer increments on its accept and wraps DEPTH-1 -> 0 (explicit compare, no power-of-two assumption).
- Standard mode (FWFT = 0):
  - On rd_acc, data_out <= mem[rd_ptr] and valid <= 1 in the next cycle (1-cycle latency).
  - Otherwise valid <= 0 and data_out holds its last value.
- FWFT mode (FWFT = 1):
  - data_out = mem[rd_ptr] combinationally and valid = !empty.
  - rd_en acts as an acknowledge that pops the head word.
  - A word written into an empty FIFO appears on data_out the cycle after the write (count becomes 1).
- Errors:
  - wr_en & !wr_acc sets overflow; rd_en & !rd_acc sets underflow. Both hold until err_clr.
  - If err_clr and a new error occur in the same cycle, the set wins.
  - The FIFO state is unchanged by a rejected request.
- flush: next cycle wr_ptr = rd_ptr = 0, count = 0, valid = 0 in standard mode.
  - flush has priority over wr_en/rd_en in the same cycle; those requests are discarded and raise no error flags.
  - flush does not clear the error flags.
- Invariant: full and empty are never both 1; count <= DEPTH always.

Test Plan:
1. FWFT=0, DEPTH=4: write 0xA1..0xA4 -> full=1, count=4, almost_full=1 at count 2; 5th write with rd_en=0 -> overflow=1, count stays 4; read 4x -> data_out A1..A4, each valid one cycle after its rd_en.
2. Full FIFO (DEPTH=4), wr_en=rd_en=1 with data_in 0xB5 -> both accepted, count stays 4, overflow stays 0; the next four reads return A2,A3,A4,B5.
3. Empty FIFO, wr_en=rd_en=1 -> write accepted, read rejected, underflow=1, count=1; err_clr pulse -> underflow=0.
4. DEPTH=5 (non-power-of-two), stream 12 words with interleaved reads -> pointers wrap 4->0 and output order equals input order.
5. FWFT=1: write 0x3C into empty -> next cycle valid=1, data_out=0x3C with no rd_en; rd_en -> following cycle empty=1, valid=0.
6. Count=3, assert flush with wr_en=1 -> next cycle count=0, empty=1, no overflow. Then pull rst_n low mid-burst -> all outputs reach reset values immediately, without waiting for clk.
